rtype_fetch_issue: RTL
======================

// Module: rtype_fetch_issue
// PURPOSE
//   Upstream feeder for the R-type ALU: sequences a PC through instruction memory, latches each word,
//   splits it into rs/rt/rd/shamt/funct and issues it to the ALU with a valid/ready handshake.
//   Filters non-R-type and unsupported funct words, and stops on a HALT sentinel.
//   Sits between the instruction ROM (synchronous, 1-cycle read) and the ALU execute stage.
// PARAMETERS
//   PC_W        6    PC/address width; IMEM holds 2**PC_W words
//   CNT_W       16   width of issued-instruction counter
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous, active-high reset
//   start          in   1      1-cycle pulse: begin fetching at PC 0 (ignored unless IDLE or HALTED)
//   imem_addr      out  PC_W   instruction memory read address
//   imem_rdata     in   32     read data, valid the cycle after imem_addr is presented
//   rs,rt,rd       out  5      register indices of issued instruction
//   shamt          out  5      shift amount
//   funct          out  6      ALU function code
//   alu_valid      out  1      fields valid, held until accepted
//   alu_ready      in   1      ALU accepts fields this cycle when alu_valid&alu_ready
//   illegal        out  1      sticky: at least one word was skipped as illegal since start
//   halted         out  1      HALT word reached
//   pc             out  PC_W   current PC
//   issued_cnt     out  CNT_W  instructions accepted by ALU since start
// BEHAVIOUR
//   Reset (async): state IDLE; pc=0, imem_addr=0, all field outputs 0, alu_valid=0, illegal=0,
//     halted=0, issued_cnt=0. Reset mid-operation aborts any pending issue immediately; no completion.
//   FSM: IDLE -start-> REQ. REQ: drive imem_addr=pc -> WAIT. WAIT: latch imem_rdata into IR -> DEC.
//   DEC: if IR==32'hFFFF_FFFF -> HALTED (halted=1, pc holds);
//        else if IR[31:26]!=6'b000000 or funct not in {100000 add,100010 sub,100100 and,100101 or,
//        101010 slt,000010 srl}: illegal<=1, pc<=pc+1 -> REQ (nothing issued);
//        else load rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], shamt=IR[10:6], funct=IR[5:0],
//        alu_valid<=1 -> ISSUE.
//   ISSUE: hold all fields and alu_valid stable; on alu_valid&alu_ready: alu_valid<=0, pc<=pc+1,
//     issued_cnt<=issued_cnt+1 -> REQ. alu_ready high in any other state has no effect.
//   HALTED: start -> clear pc, illegal, halted, issued_cnt; -> REQ. start in REQ/WAIT/DEC/ISSUE ignored.
//   Latency: first alu_valid 4 cycles after start pulse (IDLE->REQ->WAIT->DEC->ISSUE); minimum
//     4 cycles per issued instruction with alu_ready tied high; illegal word costs 3 cycles.
//   PC wraps 2**PC_W-1 -> 0 silently. issued_cnt wraps at 2**CNT_W. Field outputs keep last
//     issued value after acceptance (not cleared).
// STRUCTURE
//   Shared package alu_defs_pkg: FUNCT_ADD/SUB/AND/OR/SLT/SRL, OPC_RTYPE, HALT_WORD,
//     state enum (IDLE,REQ,WAIT,DEC,ISSUE,HALTED); reused by the ALU and its bench.
//   Sub-module rtype_field_decoder (combinational): IR -> fields, is_halt, is_legal.
//   Top holds FSM, PC, IR, output registers, counters.
// TESTING
//   Memory model: 32-entry sync ROM, 1-cycle read latency; ALU model with programmable ready.
//   1. ROM[0]=0x00221020 (add rs=1,rt=2,rd=2), ROM[1]=HALT, ready=1, start -> one issue rs=1 rt=2
//      rd=2 funct=100000 at cycle 4; then halted=1, issued_cnt=1, pc=1.
//   2. ROM[0]=srl shamt=2, ready held 0 for 6 cycles -> alu_valid and all fields constant 6 cycles,
//      pc unchanged; ready=1 -> accepted once, issued_cnt=1.
//   3. ROM[0]=0x8C000000 (lw), ROM[1]=0x00000027 (nor), ROM[2]=slt, ROM[3]=HALT -> only slt issued,
//      illegal=1, issued_cnt=1, halted at pc=3.
//   4. Assert reset while in ISSUE with alu_valid=1 -> alu_valid=0, pc=0, state IDLE same cycle
//      (async); ready asserted after reset -> no count increment.
//   5. PC_W=2, ROM all add, no HALT -> pc sequence 0,1,2,3,0,1; issued_cnt increments every accept.
//   6. start pulsed during WAIT/ISSUE -> ignored; start in HALTED -> pc=0, illegal/halted/count cleared.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - shared R-type opcode/funct constants and fetch FSM states
package alu_defs_pkg;

    localparam logic [5:0]  OPC_RTYPE = 6'b000000;
    localparam logic [5:0]  FUNCT_ADD = 6'b100000;
    localparam logic [5:0]  FUNCT_SUB = 6'b100010;
    localparam logic [5:0]  FUNCT_AND = 6'b100100;
    localparam logic [5:0]  FUNCT_OR  = 6'b100101;
    localparam logic [5:0]  FUNCT_SLT = 6'b101010;
    localparam logic [5:0]  FUNCT_SRL = 6'b000010;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        DEC    = 3'd3,
        ISSUE  = 3'd4,
        HALTED = 3'd5
    } fetch_state_t;

    // True for the funct codes the downstream ALU implements
    function automatic logic is_supported_funct(input logic [5:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
               (f == FUNCT_OR)  || (f == FUNCT_SLT) || (f == FUNCT_SRL);
    endfunction

endpackage

// File: rtl/rtype_field_decoder.sv
// rtl/rtype_field_decoder.sv - combinational split of an instruction word into R-type fields
module rtype_field_decoder
    import alu_defs_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic        is_halt,
    output logic        is_legal
);

    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];

    // HALT takes priority; it would otherwise look like an illegal opcode
    assign is_halt  = (ir == HALT_WORD);
    assign is_legal = !is_halt && (ir[31:26] == OPC_RTYPE) && is_supported_funct(ir[5:0]);

endmodule

// File: rtl/rtype_fetch_issue.sv
// rtl/rtype_fetch_issue.sv - fetches, filters and issues R-type words to the ALU
module rtype_fetch_issue
    import alu_defs_pkg::*;
#(
    parameter int PC_W  = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic             illegal,
    output logic             halted,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] issued_cnt
);

    fetch_state_t state, state_nxt;
    logic [31:0]  ir;

    logic [4:0] dec_rs, dec_rt, dec_rd, dec_shamt;
    logic [5:0] dec_funct;
    logic       dec_halt, dec_legal;

    // Control strobes produced by the FSM output process
    logic clear_run, load_ir, load_fields, skip_word, enter_halt, accept;

    rtype_field_decoder u_dec (
        .ir       (ir),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .rd       (dec_rd),
        .shamt    (dec_shamt),
        .funct    (dec_funct),
        .is_halt  (dec_halt),
        .is_legal (dec_legal)
    );

    // The ROM registers its address itself, so the address simply follows pc
    assign imem_addr = pc;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = DEC;
            DEC:     state_nxt = dec_halt ? HALTED : (dec_legal ? ISSUE : REQ);
            ISSUE:   if (alu_valid && alu_ready) state_nxt = REQ;
            HALTED:  if (start) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        clear_run   = 1'b0;
        load_ir     = 1'b0;
        load_fields = 1'b0;
        skip_word   = 1'b0;
        enter_halt  = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE, HALTED: clear_run = start;
            WAIT:         load_ir   = 1'b1;
            DEC: begin
                enter_halt  = dec_halt;
                load_fields = dec_legal;
                skip_word   = !dec_halt && !dec_legal;
            end
            ISSUE:        accept = alu_valid && alu_ready;
            default: ;
        endcase
    end

    // Datapath: IR, PC, issue fields, sticky flags and issue counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir         <= '0;
            pc         <= '0;
            rs         <= '0;
            rt         <= '0;
            rd         <= '0;
            shamt      <= '0;
            funct      <= '0;
            alu_valid  <= 1'b0;
            illegal    <= 1'b0;
            halted     <= 1'b0;
            issued_cnt <= '0;
        end else begin
            if (clear_run) begin
                pc         <= '0;
                illegal    <= 1'b0;
                halted     <= 1'b0;
                issued_cnt <= '0;
            end
            if (load_ir) ir <= imem_rdata;
            if (enter_halt) halted <= 1'b1;
            if (skip_word) begin
                illegal <= 1'b1;
                pc      <= pc + PC_W'(1);
            end
            if (load_fields) begin
                rs        <= dec_rs;
                rt        <= dec_rt;
                rd        <= dec_rd;
                shamt     <= dec_shamt;
                funct     <= dec_funct;
                alu_valid <= 1'b1;
            end
            if (accept) begin
                alu_valid  <= 1'b0;
                pc         <= pc + PC_W'(1);
                issued_cnt <= issued_cnt + CNT_W'(1);
            end
        end
    end

endmodule
